// File: rtl/enc_pulse_gen.sv
// enc_pulse_gen
// Encoder emulator, transmitter side of the A/Z interface. On I_START it
// latches period/width/count/Z-ratio and emits a deterministic A pulse train.
// A one-cycle Z pulse follows every ZNUM-th A rising edge. A running
// emitted-pulse count lets the downstream counter be checked cycle-exactly.
//
// Ports:
//   CLK, RST          clock, asynchronous active-high reset
//   I_START           start burst (honoured only when idle)
//   I_STOP            abort burst (honoured only when busy)
//   I_PERIOD/I_WIDTH  A rising-edge spacing / A high time, in cycles
//   I_NUM             A pulses per burst, 0 = run until I_STOP
//   I_ZNUM            A pulses per Z pulse, 0 = Z disabled
//   O_A, O_Z          registered A and Z outputs
//   O_BUSY, O_DONE    burst in progress / one-cycle burst-complete strobe
//   O_CNT_A           A pulses emitted since last I_START (wraps)
//   O_OVERFLOW        sticky, O_CNT_A has wrapped since last I_START
module enc_pulse_gen #(
  parameter int P_CNT_W = 64,
  parameter int P_PER_W = 16,
  parameter int P_NUM_W = 32
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               I_START,
  input  logic               I_STOP,
  input  logic [P_PER_W-1:0] I_PERIOD,
  input  logic [P_PER_W-1:0] I_WIDTH,
  input  logic [P_NUM_W-1:0] I_NUM,
  input  logic [P_NUM_W-1:0] I_ZNUM,
  output logic               O_A,
  output logic               O_Z,
  output logic               O_BUSY,
  output logic               O_DONE,
  output logic [P_CNT_W-1:0] O_CNT_A,
  output logic               O_OVERFLOW
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_HIGH = 2'd1;
  localparam logic [1:0] S_LOW  = 2'd2;

  logic [1:0]         state_q,  state_d;
  logic [P_PER_W-1:0] per_q,    per_d;
  logic [P_PER_W-1:0] wid_q,    wid_d;
  logic [P_NUM_W-1:0] num_q,    num_d;
  logic [P_NUM_W-1:0] znum_q,   znum_d;
  logic [P_PER_W-1:0] ph_q,     ph_d;      // cycles left in current phase
  logic [P_NUM_W-1:0] pulses_q, pulses_d;  // burst-length counter
  logic [P_NUM_W-1:0] zcnt_q,   zcnt_d;
  logic               zpend_q,  zpend_d;   // Z due in the cycle after HIGH entry
  logic               a_q,      a_d;
  logic               z_q,      z_d;
  logic               busy_q,   busy_d;
  logic               done_q,   done_d;
  logic [P_CNT_W-1:0] cnt_q,    cnt_d;
  logic               ovf_q,    ovf_d;

  logic [P_PER_W-1:0] p_in, w_in;
  logic               enter, first;
  logic [P_NUM_W-1:0] zn_sel, zc_next;

  // Sanitised parameters from the live inputs, used only at latch time.
  always_comb begin
    p_in = (I_PERIOD < P_PER_W'(2)) ? P_PER_W'(2) : I_PERIOD;
    if (I_WIDTH == '0)
      w_in = P_PER_W'(1);
    else if (I_WIDTH >= p_in)
      w_in = p_in - 1'b1;
    else
      w_in = I_WIDTH;
  end

  always_comb begin
    state_d  = state_q;
    per_d    = per_q;
    wid_d    = wid_q;
    num_d    = num_q;
    znum_d   = znum_q;
    ph_d     = ph_q;
    pulses_d = pulses_q;
    zcnt_d   = zcnt_q;
    zpend_d  = 1'b0;
    z_d      = zpend_q;
    done_d   = 1'b0;
    cnt_d    = cnt_q;
    ovf_d    = ovf_q;
    enter    = 1'b0;
    first    = 1'b0;
    zn_sel   = znum_q;
    zc_next  = zcnt_q;

    case (state_q)
      S_IDLE: begin
        if (I_START) begin
          per_d  = p_in;
          wid_d  = w_in;
          num_d  = I_NUM;
          znum_d = I_ZNUM;
          enter  = 1'b1;
          first  = 1'b1;
        end
      end
      S_HIGH: begin
        if (I_STOP) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
          z_d     = 1'b0;
        end else if (ph_q == '0) begin
          state_d = S_LOW;
          ph_d    = per_q - wid_q - 1'b1;
        end else begin
          ph_d = ph_q - 1'b1;
        end
      end
      S_LOW: begin
        if (I_STOP) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
          z_d     = 1'b0;
        end else if (ph_q == '0) begin
          if ((num_q != '0) && (pulses_q == num_q)) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end else begin
            enter = 1'b1;
          end
        end else begin
          ph_d = ph_q - 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // HIGH entry: shared by burst start (counters cleared first) and by
    // the LOW->HIGH wrap within a burst.
    if (enter) begin
      state_d  = S_HIGH;
      ph_d     = (first ? w_in : wid_q) - 1'b1;
      cnt_d    = (first ? '0 : cnt_q) + 1'b1;
      ovf_d    = first ? 1'b0 : (ovf_q | (&cnt_q));
      pulses_d = (first ? '0 : pulses_q) + 1'b1;
      zn_sel   = first ? I_ZNUM : znum_q;
      zc_next  = (first ? '0 : zcnt_q) + 1'b1;
      if ((zn_sel != '0) && (zc_next == zn_sel)) begin
        zpend_d = 1'b1;
        zcnt_d  = '0;
      end else begin
        zcnt_d = zc_next;
      end
    end

    a_d    = (state_d == S_HIGH);
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q  <= S_IDLE;
      per_q    <= '0;
      wid_q    <= '0;
      num_q    <= '0;
      znum_q   <= '0;
      ph_q     <= '0;
      pulses_q <= '0;
      zcnt_q   <= '0;
      zpend_q  <= 1'b0;
      a_q      <= 1'b0;
      z_q      <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      cnt_q    <= '0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      per_q    <= per_d;
      wid_q    <= wid_d;
      num_q    <= num_d;
      znum_q   <= znum_d;
      ph_q     <= ph_d;
      pulses_q <= pulses_d;
      zcnt_q   <= zcnt_d;
      zpend_q  <= zpend_d;
      a_q      <= a_d;
      z_q      <= z_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      cnt_q    <= cnt_d;
      ovf_q    <= ovf_d;
    end
  end

  assign O_A        = a_q;
  assign O_Z        = z_q;
  assign O_BUSY     = busy_q;
  assign O_DONE     = done_q;
  assign O_CNT_A    = cnt_q;
  assign O_OVERFLOW = ovf_q;

endmodule

// File: tb/tb_enc_pulse_gen.sv
// Testbench for enc_pulse_gen. Expected waveforms come from a closed-form
// model: cycle c after the start edge belongs to pulse (c-1)/P at phase
// (c-1)%P; the burst ends at min(N*P+1, stop cycle).
module tb_enc_pulse_gen;

  localparam int CW = 4;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic          I_START = 1'b0;
  logic          I_STOP = 1'b0;
  logic [15:0]   I_PERIOD = '0;
  logic [15:0]   I_WIDTH = '0;
  logic [31:0]   I_NUM = '0;
  logic [31:0]   I_ZNUM = '0;
  logic          O_A, O_Z, O_BUSY, O_DONE, O_OVERFLOW;
  logic [CW-1:0] O_CNT_A;
  logic [8:0]    obs;

  int checks = 0;
  int errors = 0;

  enc_pulse_gen #(.P_CNT_W(CW), .P_PER_W(16), .P_NUM_W(32)) dut (
    .CLK(CLK), .RST(RST), .I_START(I_START), .I_STOP(I_STOP),
    .I_PERIOD(I_PERIOD), .I_WIDTH(I_WIDTH), .I_NUM(I_NUM), .I_ZNUM(I_ZNUM),
    .O_A(O_A), .O_Z(O_Z), .O_BUSY(O_BUSY), .O_DONE(O_DONE),
    .O_CNT_A(O_CNT_A), .O_OVERFLOW(O_OVERFLOW)
  );

  always #4 CLK = ~CLK;

  assign obs = {O_A, O_Z, O_BUSY, O_DONE, O_OVERFLOW, O_CNT_A};

  function automatic int end_cycle(int p, int n, int stop_at);
    int pp, nat;
    pp  = (p < 2) ? 2 : p;
    nat = (n == 0) ? (1 << 30) : n * pp + 1;
    return (stop_at != 0 && stop_at < nat) ? stop_at : nat;
  endfunction

  // Packed as {A, Z, BUSY, DONE, OVF, CNT[3:0]}; stop_at is the first idle
  // cycle caused by I_STOP (I_STOP high during stop_at-1), 0 = no stop.
  function automatic logic [8:0] model(int c, int p, int w, int n, int zn, int stop_at);
    int pp, ww, e, k, ph, pulses;
    logic a, z, b, d, o;
    logic [3:0] cn;
    pp = (p < 2) ? 2 : p;
    ww = (w < 1) ? 1 : ((w > pp - 1) ? pp - 1 : w);
    e  = end_cycle(p, n, stop_at);
    if (c < e) begin
      k = (c - 1) / pp;
      ph = (c - 1) % pp;
      a = (ph < ww);
      z = (zn != 0) && (ph == 1) && (((k + 1) % zn) == 0);
      b = 1'b1;
      d = 1'b0;
      pulses = k + 1;
    end else begin
      a = 1'b0;
      z = 1'b0;
      b = 1'b0;
      d = (c == e);
      pulses = (e - 2) / pp + 1;
    end
    o  = (pulses >= 16);
    cn = pulses[3:0];
    return {a, z, b, d, o, cn};
  endfunction

  // Presents a start for one capture edge, then scrambles the parameter
  // inputs (the DUT must have latched them). Returns at the negedge of cycle 1.
  task automatic start_burst(input int p, input int w, input int n, input int zn);
    @(negedge CLK);
    I_PERIOD = p[15:0];
    I_WIDTH  = w[15:0];
    I_NUM    = n;
    I_ZNUM   = zn;
    I_START  = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    I_START  = 1'b0;
    I_PERIOD = 16'($urandom);
    I_WIDTH  = 16'($urandom);
    I_NUM    = $urandom;
    I_ZNUM   = $urandom;
  endtask

  task automatic test_reset();
    RST = 1'b1;
    repeat (2) @(negedge CLK);
    checks++;
    if (obs !== 9'd0) begin
      errors++;
      $display("FAIL reset_state obs=%b exp=%b", obs, 9'd0);
    end
    RST = 1'b0;
    @(negedge CLK);
    checks++;
    if (obs !== 9'd0) begin
      errors++;
      $display("FAIL idle_after_reset obs=%b exp=%b", obs, 9'd0);
    end
  endtask

  task automatic test_basic();
    logic [8:0] exp;
    start_burst(4, 1, 6, 3);
    for (int c = 1; c <= 28; c++) begin
      if (c > 1) @(negedge CLK);
      exp = model(c, 4, 1, 6, 3, 0);
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL basic c=%0d obs=%b exp=%b", c, obs, exp);
      end
    end
  endtask

  task automatic test_clamp();
    logic [8:0] exp;
    start_burst(0, 0, 3, 0);
    for (int c = 1; c <= 10; c++) begin
      if (c > 1) @(negedge CLK);
      exp = model(c, 0, 0, 3, 0, 0);
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL clamp_min c=%0d obs=%b exp=%b", c, obs, exp);
      end
    end
    start_burst(5, 9, 3, 0);
    for (int c = 1; c <= 18; c++) begin
      if (c > 1) @(negedge CLK);
      exp = model(c, 5, 9, 3, 0, 0);
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL clamp_wide c=%0d obs=%b exp=%b", c, obs, exp);
      end
    end
  endtask

  task automatic test_stop_continuous();
    logic [8:0] exp;
    start_burst(3, 1, 0, 0);
    for (int c = 1; c <= 26; c++) begin
      if (c > 1) @(negedge CLK);
      exp = model(c, 3, 1, 0, 0, 21);
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL stop_cont c=%0d obs=%b exp=%b", c, obs, exp);
      end
      I_STOP = (c == 20);
    end
    I_STOP = 1'b0;
  endtask

  task automatic test_overflow();
    logic [8:0] exp;
    start_burst(2, 1, 17, 0);
    for (int c = 1; c <= 38; c++) begin
      if (c > 1) @(negedge CLK);
      exp = model(c, 2, 1, 17, 0, 0);
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL overflow c=%0d obs=%b exp=%b", c, obs, exp);
      end
    end
    start_burst(2, 1, 1, 0);
    for (int c = 1; c <= 4; c++) begin
      if (c > 1) @(negedge CLK);
      exp = model(c, 2, 1, 1, 0, 0);
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL overflow_clear c=%0d obs=%b exp=%b", c, obs, exp);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [8:0] exp;
    start_burst(6, 3, 0, 1);
    @(negedge CLK);
    exp = model(2, 6, 3, 0, 1, 0);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL rst_mid_pre obs=%b exp=%b", obs, exp);
    end
    #1 RST = 1'b1;
    #1;
    checks++;
    if (obs !== 9'd0) begin
      errors++;
      $display("FAIL rst_mid_async obs=%b exp=%b", obs, 9'd0);
    end
    @(negedge CLK);
    RST = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge CLK);
      checks++;
      if (obs !== 9'd0) begin
        errors++;
        $display("FAIL rst_mid_idle c=%0d obs=%b exp=%b", c, obs, 9'd0);
      end
    end
    start_burst(3, 2, 2, 1);
    for (int c = 1; c <= 9; c++) begin
      if (c > 1) @(negedge CLK);
      exp = model(c, 3, 2, 2, 1, 0);
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL rst_mid_after c=%0d obs=%b exp=%b", c, obs, exp);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [8:0] exp;
    int e;
    e = end_cycle(3, 2, 0);
    @(negedge CLK);
    I_PERIOD = 16'd3;
    I_WIDTH  = 16'd1;
    I_NUM    = 32'd2;
    I_ZNUM   = 32'd2;
    I_START  = 1'b1;
    @(posedge CLK);
    for (int c = 1; c <= 2 * e + 2; c++) begin
      @(negedge CLK);
      exp = (c <= e) ? model(c, 3, 1, 2, 2, 0) : model(c - e, 3, 1, 2, 2, 0);
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL back_to_back c=%0d obs=%b exp=%b", c, obs, exp);
      end
      if (c == 2 * e) I_START = 1'b0;
    end
    I_START = 1'b0;
  endtask

  task automatic test_random();
    logic [8:0] exp;
    int p, w, n, zn, stop_at, lim, pp;
    for (int it = 0; it < 10; it++) begin
      p  = $urandom_range(0, 7);
      w  = $urandom_range(0, 8);
      n  = $urandom_range(0, 5);
      zn = $urandom_range(0, 4);
      pp = (p < 2) ? 2 : p;
      if (n == 0)
        stop_at = $urandom_range(2, 30);
      else if ($urandom_range(0, 1) == 1)
        stop_at = $urandom_range(2, n * pp + 3);
      else
        stop_at = 0;
      lim = end_cycle(p, n, stop_at) + 3;
      start_burst(p, w, n, zn);
      for (int c = 1; c <= lim; c++) begin
        if (c > 1) @(negedge CLK);
        exp = model(c, p, w, n, zn, stop_at);
        checks++;
        if (obs !== exp) begin
          errors++;
          $display("FAIL random it=%0d p=%0d w=%0d n=%0d zn=%0d stop=%0d c=%0d obs=%b exp=%b",
                   it, p, w, n, zn, stop_at, c, obs, exp);
        end
        I_STOP = (stop_at != 0) && (c == stop_at - 1);
      end
      I_STOP = 1'b0;
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_clamp();
    test_stop_continuous();
    test_overflow();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/enc_pulse_gen.md
# enc_pulse_gen

Programmable quadrature-less encoder emulator: generates the A-pulse and Z-index waveforms that the encoder counter consumes (transmitter side of the A/Z interface). Given a period, high width, burst length and Z ratio, it emits a deterministic A pulse train and a one-cycle Z pulse every Nth A pulse. It also keeps a running emitted-pulse count, so the counter's O_CNT_A value can be checked cycle-exactly on hardware and in regression.

## Interface

Parameters:
- P_CNT_W, 64, width of emitted-pulse counter O_CNT_A
- P_PER_W, 16, width of I_PERIOD / I_WIDTH
- P_NUM_W, 32, width of I_NUM / I_ZNUM

Ports:
- CLK  in  1  system clock (128 MHz nominal)
- RST  in  1  reset; one clock; reset is asynchronous and active-high
- I_START  in  1  start burst; sampled only in IDLE
- I_STOP  in  1  abort burst; sampled in any non-IDLE state
- I_PERIOD  in  P_PER_W  A rising-edge spacing, in cycles
- I_WIDTH  in  P_PER_W  A high time, in cycles
- I_NUM  in  P_NUM_W  A pulses per burst; 0 = continuous until I_STOP
- I_ZNUM  in  P_NUM_W  A pulses per Z pulse; 0 = Z disabled
- O_A  out  1  A pulse output, registered
- O_Z  out  1  Z index output, registered
- O_BUSY  out  1  burst in progress
- O_DONE  out  1  one-cycle burst-complete strobe
- O_CNT_A  out  P_CNT_W  A pulses emitted since last I_START
- O_OVERFLOW  out  1  sticky; O_CNT_A wrapped

## Operation

- States: IDLE, HIGH, LOW.
- IDLE:
  - On I_START=1, latch I_PERIOD, I_WIDTH, I_NUM, I_ZNUM into shadow registers.
  - Clear O_CNT_A, O_OVERFLOW and the Z counter, then go to HIGH.
  - Inputs are ignored after latch; I_START outside IDLE is ignored.
- Parameter sanitising at latch:
  - Period P = max(I_PERIOD, 2).
  - Width W = I_WIDTH clamped to 1..P-1.
- HIGH:
  - O_A=1 for W cycles.
  - On entry, O_CNT_A increments and the pulse counter increments.
  - After W cycles, go to LOW.
- LOW:
  - O_A=0 for P-W cycles.
  - Then, if I_NUM≠0 and pulses emitted == I_NUM, go to IDLE with O_DONE=1 for one cycle; otherwise go to HIGH.
- Z:
  - Z counter increments on each HIGH entry.
  - When it reaches ZNUM (ZNUM≠0), O_Z=1 for exactly the one cycle following the HIGH-entry cycle, and the Z counter resets to 0.
  - If W=1, that Z cycle is the first LOW cycle.
- I_STOP in HIGH/LOW:
  - Next cycle: O_A=0, state IDLE, O_DONE=1 for one cycle.
  - A pending Z is suppressed.
  - O_CNT_A holds its value.
- Priority: I_STOP beats the natural burst end; both produce a single O_DONE.
- O_CNT_A wraps modulo 2^P_CNT_W. O_OVERFLOW is set on the wrap cycle and holds until the next I_START or RST.
- O_CNT_A and O_OVERFLOW hold after a burst until the next I_START.
- RST (any time, async): state IDLE; all outputs 0; shadow and Z counters 0. A burst in progress is lost and no O_DONE is produced.

## Timing

- All outputs are registered. Reset value of every output is 0.
- I_START sampled high at edge t0 gives O_A=1, O_BUSY=1, and O_CNT_A=1 from cycle t0+1.
- A rising edges occur at t0+1+k·P for k=0..N-1.
- Last LOW cycle is t0+N·P. Then, at cycle t0+N·P+1:
  - O_DONE=1 for that cycle;
  - O_BUSY=0;
  - a new I_START can be accepted at that edge.
- Z for the j-th Z-multiple pulse, rising at cycle r, is high at cycle r+1 only.
- I_STOP sampled at edge t drives O_A=0 and O_DONE=1 in cycle t+1.

## Test plan

- **Basic burst:** P=4, W=1, N=6, ZNUM=3, start at t0.
  - O_A high at cycles 1,5,9,13,17,21.
  - O_Z high at 10 and 22 only.
  - O_DONE and O_BUSY fall at 25.
  - O_CNT_A=6.
- **Clamping:** P=0, W=0, N=3.
  - Behaves as P=2, W=1: A at 1,3,5; done at 7.
  - With P=5, W=9: A high 4 cycles, low 1.
- **Continuous stop:** N=0, P=3, W=1, ZNUM=0.
  - Runs continuously; O_Z stays 0.
  - I_STOP at edge 20: O_A=0 and O_DONE=1 at 21; O_CNT_A=7; no further pulses.
- **Overflow:** P_CNT_W=4, N=17.
  - Final O_CNT_A=1 and O_OVERFLOW=1.
  - Next I_START clears both.
- **Reset mid-burst:** RST asserted async between edges during HIGH.
  - O_A, O_CNT_A, O_BUSY go 0 immediately; no O_DONE.
  - After release, a new burst runs correctly.
- **Back-to-back start:** I_START held high continuously.
  - Ignored while busy.
  - A new burst starts on the O_DONE cycle edge, with A at t+1 and counters cleared.
